// File: rtl/sap_control_sequencer_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: widths, opcodes,
// control-word bit positions and one-hot T-state encodings.
package sap_control_sequencer_pkg;

    localparam int OPW = 4;   // opcode width (IR upper nibble)
    localparam int NT  = 6;   // ring-counter states per machine cycle
    localparam int CWW = 12;  // control-word width

    typedef logic [OPW-1:0] opcode_t;
    typedef logic [NT-1:0]  tstate_t;
    typedef logic [CWW-1:0] cword_t;

    localparam opcode_t OP_LDA = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_SUB = 4'b0010;
    localparam opcode_t OP_OUT = 4'b1110;
    localparam opcode_t OP_HLT = 4'b1111;

    // Control-word bit order {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    // Single-bit control word, used to build the decode table readably.
    function automatic cword_t cw(input int idx);
        cword_t c;
        c      = '0;
        c[idx] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Opcode-in / control-out bundle between the SAP-1 datapath and its sequencer.
// master = datapath side (supplies the opcode), slave = sequencer side.
interface sap_control_sequencer_if;
    import sap_control_sequencer_pkg::*;

    opcode_t opcode;
    cword_t  con;
    tstate_t tstate;
    logic    halted;

    modport master (output opcode, input con, input tstate, input halted);
    modport slave  (input opcode, output con, output tstate, output halted);

endinterface

// File: rtl/sap_control_sequencer_ring_counter.sv
// One-hot T-state ring counter (T1..T6). hold freezes the current state,
// restart forces a return to T1 on the next edge (variable-length cycles).
module sap_ring_counter
    import sap_control_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    clr,
    input  logic    hold,
    input  logic    restart,
    output tstate_t tstate
);

    tstate_t tstate_q;
    tstate_t tstate_d;

    // Next state: hold wins over restart, restart wins over rotation.
    always_comb begin
        tstate_d = tstate_q;
        if (!hold) begin
            if (restart) tstate_d = T1;
            else         tstate_d = {tstate_q[NT-2:0], tstate_q[NT-1]};
        end
    end

    // State register; clr returns to T1 without waiting for a clock.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) tstate_q <= T1;
        else     tstate_q <= tstate_d;
    end

    assign tstate = tstate_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 controller-sequencer top: ring counter, Moore decode of
// {tstate, opcode} into the control word, and the sticky halt flag.
// Optional build macro SAP_SEQ_EARLY_RETIRE_EN: end each machine cycle after
// its last state with a nonzero control word (LDA 5, OUT/NOP 4, ADD/SUB 6).
module sap_control_sequencer
    import sap_control_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     clr,
    sap_control_sequencer_if.slave   bus
);

    tstate_t tstate;
    logic    halted_q;
    logic    halted_d;
    logic    hold;
    logic    restart;
    cword_t  con_d;

    // HLT seen in T4 freezes the ring on that same edge, then the flag keeps it frozen.
    assign halted_d = halted_q | ((tstate == T4) && (bus.opcode == OP_HLT));
    assign hold     = halted_d;

`ifdef SAP_SEQ_EARLY_RETIRE_EN
    // Restart after the last state carrying a nonzero control word.
    always_comb begin
        restart = 1'b0;
        case (tstate)
            T4: restart = (bus.opcode != OP_LDA) && (bus.opcode != OP_ADD) &&
                          (bus.opcode != OP_SUB) && (bus.opcode != OP_HLT);
            T5: restart = (bus.opcode == OP_LDA);
            default: restart = 1'b0;
        endcase
    end
`else
    assign restart = 1'b0;
`endif

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (hold),
        .restart (restart),
        .tstate  (tstate)
    );

    // Sticky halt flag; only clr clears it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    // Control-word decode: fetch is common, execute depends on the opcode.
    always_comb begin
        con_d = '0;
        case (tstate)
            T1: con_d = cw(CW_EP) | cw(CW_LM);
            T2: con_d = cw(CW_CP);
            T3: con_d = cw(CW_CE) | cw(CW_LI);
            T4: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB: con_d = cw(CW_EI) | cw(CW_LM);
                    OP_OUT:                 con_d = cw(CW_EA) | cw(CW_LO);
                    default:                con_d = '0;
                endcase
            end
            T5: begin
                case (bus.opcode)
                    OP_LDA:         con_d = cw(CW_CE) | cw(CW_LA);
                    OP_ADD, OP_SUB: con_d = cw(CW_CE) | cw(CW_LB);
                    default:        con_d = '0;
                endcase
            end
            T6: begin
                case (bus.opcode)
                    OP_ADD:  con_d = cw(CW_EU) | cw(CW_LA);
                    OP_SUB:  con_d = cw(CW_SU) | cw(CW_EU) | cw(CW_LA);
                    default: con_d = '0;
                endcase
            end
            default: con_d = '0;
        endcase
    end

    assign bus.con    = halted_q ? '0 : con_d;
    assign bus.tstate = tstate;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer, with a small SAP-1
// datapath/RAM model for the program run. Works for both build variants.
module tb_sap_control_sequencer;
    import sap_control_sequencer_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic    prog_mode = 1'b0;
    opcode_t opc_drv   = 4'h0;

    sap_control_sequencer_if sif ();

    sap_control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [7:0] ram [16];
    logic [3:0] pc_m, mar_m;
    logic [7:0] ir_m, a_m, b_m, out_m;
    logic [7:0] wbus;

    assign sif.opcode = prog_mode ? ir_m[7:4] : opc_drv;

    always_comb begin
        wbus = 8'h00;
        if (sif.con[CW_EP]) wbus = {4'h0, pc_m};
        if (sif.con[CW_CE]) wbus = ram[mar_m];
        if (sif.con[CW_EI]) wbus = {4'h0, ir_m[3:0]};
        if (sif.con[CW_EA]) wbus = a_m;
        if (sif.con[CW_EU]) wbus = sif.con[CW_SU] ? (a_m - b_m) : (a_m + b_m);
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_m <= 4'h0; mar_m <= 4'h0; ir_m <= 8'h00;
            a_m <= 8'h00; b_m <= 8'h00; out_m <= 8'h00;
        end else begin
            if (sif.con[CW_CP]) pc_m  <= pc_m + 4'h1;
            if (sif.con[CW_LM]) mar_m <= wbus[3:0];
            if (sif.con[CW_LI]) ir_m  <= wbus;
            if (sif.con[CW_LA]) a_m   <= wbus;
            if (sif.con[CW_LB]) b_m   <= wbus;
            if (sif.con[CW_LO]) out_m <= wbus;
        end
    end

    // Every cycle: single bus driver and exactly one T-state bit.
    always @(negedge clk) begin
        if (!clr) begin
            logic [4:0] en;
            en = {sif.con[CW_EP], sif.con[CW_CE], sif.con[CW_EI], sif.con[CW_EA], sif.con[CW_EU]};
            checks++;
            if (!$onehot0(en)) begin
                errors++;
                $display("FAIL bus_driver: enables=%b required at most one set", en);
            end
            checks++;
            if (!$onehot(sif.tstate)) begin
                errors++;
                $display("FAIL tstate_onehot: tstate=%b required exactly one bit", sif.tstate);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (sif.tstate !== T1) begin errors++; $display("FAIL reset_tstate: got %b want %b", sif.tstate, T1); end
        checks++;
        if (sif.con !== 12'h600) begin errors++; $display("FAIL reset_con: got %h want 600", sif.con); end
        checks++;
        if (sif.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", sif.halted); end
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (sif.con !== 12'h600) begin errors++; $display("FAIL t1_con: got %h want 600", sif.con); end
    endtask

    task automatic test_fetch();
        step();
        checks++;
        if (sif.tstate !== T2 || sif.con !== 12'h800) begin
            errors++; $display("FAIL fetch_t2: got %b/%h want %b/800", sif.tstate, sif.con, T2);
        end
        step();
        checks++;
        if (sif.tstate !== T3 || sif.con !== 12'h180) begin
            errors++; $display("FAIL fetch_t3: got %b/%h want %b/180", sif.tstate, sif.con, T3);
        end
    endtask

    // Runs one machine cycle of the given opcode from T1 and checks T4..T6.
    task automatic run_exec(input opcode_t op, input cword_t e4, input cword_t e5, input cword_t e6,
                            input string nm);
        pulse_clr();
        opc_drv = op;
        step(); step(); step();
        checks++;
        if (sif.tstate !== T4 || sif.con !== e4) begin
            errors++; $display("FAIL %s_t4: got %b/%h want %b/%h", nm, sif.tstate, sif.con, T4, e4);
        end
        step();
        checks++;
        if (sif.tstate !== T5 || sif.con !== e5) begin
            errors++; $display("FAIL %s_t5: got %b/%h want %b/%h", nm, sif.tstate, sif.con, T5, e5);
        end
        step();
        checks++;
        if (sif.tstate !== T6 || sif.con !== e6) begin
            errors++; $display("FAIL %s_t6: got %b/%h want %b/%h", nm, sif.tstate, sif.con, T6, e6);
        end
        step();
        checks++;
        if (sif.tstate !== T1 || sif.con !== 12'h600) begin
            errors++; $display("FAIL %s_wrap: got %b/%h want %b/600", nm, sif.tstate, sif.con, T1);
        end
    endtask

    task automatic test_add_sub();
        run_exec(OP_ADD, 12'h240, 12'h102, 12'h024, "add");
        run_exec(OP_SUB, 12'h240, 12'h102, 12'h02C, "sub");
    endtask

    // Short-cycle opcodes: check the last useful state and where the ring goes next.
    task automatic test_short_ops();
        tstate_t want;
        // LDA
        pulse_clr();
        opc_drv = OP_LDA;
        step(); step(); step();
        checks++;
        if (sif.con !== 12'h240) begin errors++; $display("FAIL lda_t4: got %h want 240", sif.con); end
        step();
        checks++;
        if (sif.tstate !== T5 || sif.con !== 12'h120) begin
            errors++; $display("FAIL lda_t5: got %b/%h want %b/120", sif.tstate, sif.con, T5);
        end
        step();
`ifdef SAP_SEQ_EARLY_RETIRE_EN
        want = T1;
`else
        want = T6;
`endif
        checks++;
        if (sif.tstate !== want) begin errors++; $display("FAIL lda_after_t5: got %b want %b", sif.tstate, want); end
        // OUT
        pulse_clr();
        opc_drv = OP_OUT;
        step(); step(); step();
        checks++;
        if (sif.tstate !== T4 || sif.con !== 12'h011) begin
            errors++; $display("FAIL out_t4: got %b/%h want %b/011", sif.tstate, sif.con, T4);
        end
        step();
`ifdef SAP_SEQ_EARLY_RETIRE_EN
        want = T1;
`else
        want = T5;
`endif
        checks++;
        if (sif.tstate !== want) begin errors++; $display("FAIL out_after_t4: got %b want %b", sif.tstate, want); end
        // NOP (undefined opcode)
        pulse_clr();
        opc_drv = 4'b0101;
        step(); step(); step();
        checks++;
        if (sif.tstate !== T4 || sif.con !== 12'h000) begin
            errors++; $display("FAIL nop_t4: got %b/%h want %b/000", sif.tstate, sif.con, T4);
        end
        step();
        checks++;
        if (sif.tstate !== want) begin errors++; $display("FAIL nop_after_t4: got %b want %b", sif.tstate, want); end
    endtask

    task automatic test_halt();
        pulse_clr();
        opc_drv = OP_HLT;
        step(); step(); step();
        checks++;
        if (sif.tstate !== T4 || sif.con !== 12'h000 || sif.halted !== 1'b0) begin
            errors++; $display("FAIL hlt_t4: got %b/%h/%b want %b/000/0", sif.tstate, sif.con, sif.halted, T4);
        end
        step();
        checks++;
        if (sif.halted !== 1'b1 || sif.tstate !== T4) begin
            errors++; $display("FAIL hlt_set: got halted=%b tstate=%b want 1/%b", sif.halted, sif.tstate, T4);
        end
        // An ADD opcode would decode to 240 at T4; halt must mask it.
        opc_drv = OP_ADD;
        repeat (20) step();
        checks++;
        if (sif.tstate !== T4 || sif.con !== 12'h000 || sif.halted !== 1'b1) begin
            errors++; $display("FAIL hlt_frozen: got %b/%h/%b want %b/000/1", sif.tstate, sif.con, sif.halted, T4);
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if (sif.tstate !== T1 || sif.halted !== 1'b0) begin
            errors++; $display("FAIL hlt_clr: got %b/%b want %b/0", sif.tstate, sif.halted, T1);
        end
        #1;
        clr = 1'b0;
    endtask

    task automatic test_async_clr();
        pulse_clr();
        opc_drv = OP_ADD;
        step(); step(); step(); step();
        checks++;
        if (sif.tstate !== T5) begin errors++; $display("FAIL async_pre: got %b want %b", sif.tstate, T5); end
        #1;
        clr = 1'b1;
        #1;
        checks++;
        if (sif.tstate !== T1 || sif.con !== 12'h600) begin
            errors++; $display("FAIL async_clr: got %b/%h want %b/600", sif.tstate, sif.con, T1);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    // LDA 9 / ADD A / OUT / HLT with 0x12 + 0x34.
    task automatic test_program();
        int n;
        int want_n;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0]  = 8'h09;
        ram[1]  = 8'h1A;
        ram[2]  = 8'hE0;
        ram[3]  = 8'hF0;
        ram[9]  = 8'h12;
        ram[10] = 8'h34;
        prog_mode = 1'b1;
        pulse_clr();
        n = 0;
        while (sif.halted !== 1'b1 && n < 60) begin
            step();
            n++;
        end
`ifdef SAP_SEQ_EARLY_RETIRE_EN
        want_n = 19;
`else
        want_n = 22;
`endif
        checks++;
        if (n != want_n) begin errors++; $display("FAIL prog_cycles: got %0d want %0d", n, want_n); end
        checks++;
        if (out_m !== 8'h46) begin errors++; $display("FAIL prog_out: got %h want 46", out_m); end
        checks++;
        if (a_m !== 8'h46) begin errors++; $display("FAIL prog_a: got %h want 46", a_m); end
        prog_mode = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_fetch();
        test_add_sub();
        test_short_ops();
        test_halt();
        test_async_clr();
        test_program();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
